// File: rtl/net_router_input_unit.sv
// -----------------------------------------------------------------------------
// net_router_input_unit
//
// Input stage of a 4-node ring router. Incoming messages are buffered in a
// small circular FIFO. The output port for each message is computed once, at
// enqueue time, from the 2-bit destination field in the header. That one-hot
// route is stored next to the message. The head entry is then offered to
// exactly one of the three router outputs (west, terminal, east).
//
// Handshake (upstream and downstream): a transfer happens on a rising clk edge
// when valid and ready are both high in that cycle. Valid never depends
// combinationally on the matching ready. Once the head is offered, its message
// and route stay stable until it is accepted.
//
// Parameters
//   p_router_id    this router's node ID (0..3)
//   p_msg_nbits    full message width; the header is the top 12 bits
//                  ({dest[1:0], src[1:0], opaque[7:0]})
//   p_num_entries  FIFO depth (>= 2); any value, power of two not required
//
// Ports
//   clk      rising-edge clock
//   reset    asynchronous assert, synchronous release, active low
//   in_msg   incoming message
//   in_val   upstream valid
//   in_rdy   space available (low while reset is asserted)
//   out_msg  head message, shared by all three outputs
//   out_val  per-output valid, [0] west, [1] terminal, [2] east (one-hot or 0)
//   out_rdy  per-output ready, same indexing as out_val
//   count    current FIFO occupancy
//
// Build option
//   NET_ROUTE_SHORTEST_EN  when defined: bidirectional shortest-path routing,
//                          where distance 3 goes west and the distance-2 tie
//                          goes east. When undefined: unidirectional ring,
//                          where every non-local message goes east and
//                          out_val[0] is tied low.
// -----------------------------------------------------------------------------
module net_router_input_unit #(
    parameter int p_router_id   = 0,
    parameter int p_msg_nbits   = 44,
    parameter int p_num_entries = 2
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [p_msg_nbits-1:0]             in_msg,
    input  logic                               in_val,
    output logic                               in_rdy,
    output logic [p_msg_nbits-1:0]             out_msg,
    output logic [2:0]                         out_val,
    input  logic [2:0]                         out_rdy,
    output logic [$clog2(p_num_entries+1)-1:0] count
);

    localparam int CW = $clog2(p_num_entries + 1);
    localparam int PW = (p_num_entries > 1) ? $clog2(p_num_entries) : 1;

    localparam logic [PW-1:0] LAST_IDX  = PW'(p_num_entries - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(p_num_entries);
    localparam logic [1:0]    ROUTER_ID = 2'(p_router_id);

    // One-hot route encodings, indexed like out_val.
    localparam logic [2:0] ROUTE_WEST = 3'b001;
    localparam logic [2:0] ROUTE_TERM = 3'b010;
    localparam logic [2:0] ROUTE_EAST = 3'b100;

`ifdef NET_ROUTE_SHORTEST_EN
    localparam logic [2:0] ROUTE_MASK = 3'b111;
`else
    // Unidirectional ring: the west output can never be requested.
    localparam logic [2:0] ROUTE_MASK = 3'b110;
`endif

    // ------------------------------------------------------------------
    // Route computation on the incoming message
    // ------------------------------------------------------------------
    logic [1:0] in_dest;
    logic [1:0] in_dist;
    logic [2:0] in_route;

    assign in_dest = in_msg[p_msg_nbits-1 -: 2];
    // 2-bit subtraction wraps naturally, which gives the hop distance going
    // east around the 4-node ring.
    assign in_dist = in_dest - ROUTER_ID;

    always_comb begin
        in_route = ROUTE_EAST;
        if (in_dist == 2'd0) begin
            in_route = ROUTE_TERM;
        end
`ifdef NET_ROUTE_SHORTEST_EN
        else if (in_dist == 2'd3) begin
            in_route = ROUTE_WEST;
        end
`endif
    end

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [p_msg_nbits-1:0] msg_q   [p_num_entries];
    logic [2:0]             route_q [p_num_entries];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic [2:0]    head_route;
    logic          enq;
    logic          deq;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == FULL_CNT);

    // in_rdy depends only on state and reset. It never depends on out_rdy,
    // so a full FIFO does not accept a message in the same cycle as a
    // dequeue.
    assign in_rdy = !fifo_full && reset;

    assign head_route = route_q[rd_ptr_q] & ROUTE_MASK;
    assign out_msg    = msg_q[rd_ptr_q];
    assign out_val    = fifo_empty ? 3'b000 : head_route;
    assign count      = count_q;

    assign enq = in_val && in_rdy;
    // Ready bits on outputs that are not being offered the head are ignored.
    assign deq = |(out_val & out_rdy);

    // ------------------------------------------------------------------
    // Next-state logic for pointers and occupancy
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (enq) begin
            wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + PW'(1);
        end

        if (deq) begin
            rd_ptr_d = (rd_ptr_q == LAST_IDX) ? '0 : rd_ptr_q + PW'(1);
        end

        unique case ({enq, deq})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is not reset. An entry is only observable once count
    // covers it, and by then it has been written.
    always_ff @(posedge clk) begin
        if (enq) begin
            msg_q[wr_ptr_q]   <= in_msg;
            route_q[wr_ptr_q] <= in_route;
        end
    end

endmodule

// File: tb/tb_net_router_input_unit.sv
module tb_net_router_input_unit;

    localparam int W  = 44;
    localparam int N  = 3;
    localparam int ID = 1;
    localparam int CW = $clog2(N + 1);

    // ---------------- clock / reset ----------------
    logic          clk     = 1'b0;
    logic          reset   = 1'b0;
    logic [W-1:0]  in_msg  = '0;
    logic          in_val  = 1'b0;
    logic          in_rdy;
    logic [W-1:0]  out_msg;
    logic [2:0]    out_val;
    logic [2:0]    out_rdy = 3'b000;
    logic [CW-1:0] count;

    always #5 clk = ~clk;

    net_router_input_unit #(
        .p_router_id  (ID),
        .p_msg_nbits  (W),
        .p_num_entries(N)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .in_msg (in_msg),
        .in_val (in_val),
        .in_rdy (in_rdy),
        .out_msg(out_msg),
        .out_val(out_val),
        .out_rdy(out_rdy),
        .count  (count)
    );

    // ---------------- scoreboard / reference model ----------------
    int           tests     = 0;
    int           fails     = 0;
    int           delivered = 0;
    bit           last_enq  = 1'b0;
    bit           west_seen = 1'b0;
    logic [W-1:0] exp_q[$];

    // Route from the ring rules: hop distance going east, mod 4.
    function automatic logic [2:0] exp_route(input logic [W-1:0] m);
        int dest;
        int d;
        dest = int'(m[W-1 -: 2]);
        d    = (dest + 4 - ID) % 4;
        if (d == 0) return 3'b010;
`ifdef NET_ROUTE_SHORTEST_EN
        if (d == 3) return 3'b001;
`endif
        return 3'b100;
    endfunction

    function automatic logic [W-1:0] make_msg(input int dest, input int src, input int opq);
        logic [W-1:0] m;
        m[W-13:0]   = $urandom;
        m[W-1 -: 2] = dest[1:0];
        m[W-3 -: 2] = src[1:0];
        m[W-5 -: 8] = opq[7:0];
        return m;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string where);
        logic [2:0] ev;
        ev = (exp_q.size() != 0) ? exp_route(exp_q[0]) : 3'b000;
        if (out_val[0] === 1'b1) west_seen = 1'b1;
        check({where, ".count"},   W'(count),   W'(exp_q.size()));
        check({where, ".in_rdy"},  W'(in_rdy),  W'(reset && (exp_q.size() != N)));
        check({where, ".out_val"}, W'(out_val), W'(ev));
        if (exp_q.size() != 0)
            check({where, ".out_msg"}, out_msg, exp_q[0]);
    endtask

    // ---------------- driver: one clock cycle ----------------
    // Inputs are already set. The outputs are checked on the falling edge,
    // and the model is then advanced with the handshake that occurs on the
    // rising edge.
    task automatic cycle(input string where);
        bit enq;
        bit deq;
        @(negedge clk);
        check_outputs(where);
        enq = in_val && reset && (exp_q.size() != N);
        deq = (exp_q.size() != 0) && ((exp_route(exp_q[0]) & out_rdy) != 3'b000);
        @(posedge clk);
        if (deq) begin
            void'(exp_q.pop_front());
            delivered++;
        end
        if (enq) exp_q.push_back(in_msg);
        last_enq = enq;
        #1;
    endtask

    task automatic drain(input string where);
        out_rdy = 3'b111;
        in_val  = 1'b0;
        for (int k = 0; k < 4 * N && exp_q.size() != 0; k++) cycle(where);
        check({where, ".drained"}, W'(count), W'(0));
        out_rdy = 3'b000;
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [W-1:0] m;
        logic [W-1:0] held;
        logic [W-1:0] msgs[10];
        logic [2:0]   exp_dec[3];
        int           dec_dest[3];
        int           idx;
        int           ncyc;

        dec_dest[0] = 2; dec_dest[1] = 3; dec_dest[2] = 0;
`ifdef NET_ROUTE_SHORTEST_EN
        exp_dec[0] = 3'b100; exp_dec[1] = 3'b100; exp_dec[2] = 3'b001;
`else
        exp_dec[0] = 3'b100; exp_dec[1] = 3'b100; exp_dec[2] = 3'b100;
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("release.in_rdy", W'(in_rdy), W'(1));
        @(posedge clk);
        #1;

        // Local delivery
        m      = make_msg(1, 0, 8'hA5);
        in_msg = m;
        in_val = 1'b1;
        cycle("local_enq");
        in_val = 1'b0;
        check("local.out_val", W'(out_val), W'(3'b010));
        check("local.header",  W'(out_msg[W-1 -: 12]), W'(12'h4A5));
        out_rdy = 3'b010;
        cycle("local_deq");
        out_rdy = 3'b000;
        check("local.count", W'(count), W'(0));

        // Route decode
        for (int i = 0; i < 3; i++) begin
            in_msg = make_msg(dec_dest[i], ID, i);
            in_val = 1'b1;
            cycle("decode_enq");
            in_val = 1'b0;
            check($sformatf("decode.dest%0d", dec_dest[i]), W'(out_val), W'(exp_dec[i]));
            out_rdy = 3'b111;
            cycle("decode_deq");
            out_rdy = 3'b000;
        end

        // Back-pressure and full: N+1 east-bound messages with in_val held
        idx = 0;
        for (int k = 0; k < N + 1; k++) begin
            in_msg = make_msg(3, 0, 8'h10 + idx);
            in_val = 1'b1;
            cycle("full_fill");
            if (last_enq) idx++;
        end
        check("full.accepted", W'(idx), W'(N));
        check("full.count",    W'(count), W'(N));
        check("full.in_rdy",   W'(in_rdy), W'(0));
        out_rdy = 3'b100;
        cycle("full_deq");
        check("full.no_bypass", W'(last_enq), W'(0));
        out_rdy = 3'b000;
        cycle("full_late");
        check("full.late_accept", W'(last_enq), W'(1));
        in_val = 1'b0;
        drain("full_drain");

        // Wrong-port ready
        in_msg = make_msg(3, 2, 8'h77);
        in_val = 1'b1;
        cycle("wrong_enq");
        in_val  = 1'b0;
        held    = out_msg;
        out_rdy = 3'b011;
        cycle("wrong_hold0");
        cycle("wrong_hold1");
        check("wrong.count", W'(count), W'(1));
        check("wrong.msg",   out_msg,  held);
        out_rdy = 3'b100;
        cycle("wrong_deq");
        out_rdy = 3'b000;
        check("wrong.dequeued", W'(count), W'(0));

        // Streaming with pointer wrap
        for (int i = 0; i < 10; i++) msgs[i] = make_msg($urandom_range(0, 3), 0, i);
        out_rdy   = 3'b111;
        idx       = 0;
        ncyc      = 0;
        delivered = 0;
        while ((idx < 10 || exp_q.size() != 0) && ncyc < 40) begin
            in_val = (idx < 10);
            in_msg = msgs[(idx < 10) ? idx : 9];
            cycle("stream");
            if (last_enq) idx++;
            ncyc++;
        end
        in_val  = 1'b0;
        out_rdy = 3'b000;
        check("stream.delivered", W'(delivered), W'(10));
        check("stream.cycles",    W'(ncyc),      W'(11));

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            in_val  = 1'($urandom_range(0, 1));
            in_msg  = make_msg($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255));
            out_rdy = 3'($urandom_range(0, 7));
            cycle("random");
        end
        drain("random_drain");

        // Asynchronous reset with two messages buffered
        for (int k = 0; k < 2; k++) begin
            in_msg = make_msg(3, 0, 8'hC0 + k);
            in_val = 1'b1;
            cycle("areset_fill");
        end
        in_val = 1'b0;
        check("areset.pre_count", W'(count), W'(2));
        #2;
        reset = 1'b0;
        #1;
        exp_q.delete();
        check("areset.out_val", W'(out_val), W'(0));
        check("areset.count",   W'(count),   W'(0));
        check("areset.in_rdy",  W'(in_rdy),  W'(0));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        in_msg = make_msg(2, 1, 8'h5A);
        in_val = 1'b1;
        cycle("post_reset_enq");
        in_val  = 1'b0;
        out_rdy = 3'b111;
        cycle("post_reset_deq");
        out_rdy = 3'b000;
        check("post_reset.count", W'(count), W'(0));

`ifndef NET_ROUTE_SHORTEST_EN
        check("uni.west_never", W'(west_seen), W'(0));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

endmodule
